// File: rtl/store_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_seq_pkg
// Description : Shared types and constants for the store-size sequencer:
//               FSM state encoding, merge-mux select codes and the reserved
//               store_op code.
// Revision    : 1.0 - initial release
// ============================================================================
package store_seq_pkg;

    // FSM state encoding, explicit 3-bit width
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_LD_MDR  = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Merge-mux select codes (also the store_op encoding for legal ops)
    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    // Reserved store_op, executed as a word store
    localparam logic [1:0] OP_RSVD   = 2'b11;

endpackage : store_seq_pkg
`default_nettype wire

// File: rtl/store_size_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : store_size_sequencer
// Description : Multicycle control FSM sequencing sw/sh/sb stores through the
//               memory, MDR and store-size merge datapath. Word stores write
//               directly; half/byte stores read the target word into MDR,
//               select the merge mux and write the merged word back.
// Parameters  : MEM_LAT - cycles mem_rd is held before read data is valid
//                         (1..15)
//               CNT_W   - latency counter width, 2**CNT_W > MEM_LAT
// Ports       : clk       - system clock, rising edge
//               reset     - synchronous active-high reset
//               start     - store request, sampled only in IDLE
//               store_op  - 00 word, 01 half, 10 byte, 11 reserved (word)
//               addr_lo   - effective address [1:0] (alignment check only)
//               busy      - high in every non-IDLE state
//               done      - one-cycle completion pulse
//               mem_rd    - memory read enable
//               mem_wr    - memory write enable
//               mdr_load  - MDR write enable
//               size_ctrl - merge-mux select: 01 half, 10 byte, 00 word
//               misalign  - alignment fault pulse, coincident with done
// Macros      : STORE_ALIGN_CHECK_EN - enables the alignment fault check;
//               when undefined misalign is tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module store_size_sequencer
    import store_seq_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] store_op,
    input  logic [1:0] addr_lo,
    output logic       busy,
    output logic       done,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       mdr_load,
    output logic [1:0] size_ctrl,
    output logic       misalign
);

    localparam logic [CNT_W-1:0] c_LAT_M1 = CNT_W'(MEM_LAT - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_size;
    logic             r_fault;

    logic [1:0]       w_op;
    logic             w_fault;

    // Reserved op collapses to a word store before it is latched
    assign w_op = (store_op == OP_RSVD) ? SIZE_WORD : store_op;

`ifdef STORE_ALIGN_CHECK_EN
    // Byte stores are always aligned; halves need bit 0 clear, words both.
    assign w_fault = ((w_op == SIZE_HALF) && addr_lo[0]) ||
                     ((w_op == SIZE_WORD) && (addr_lo != 2'b00));
`else
    logic w_unused_addr_lo;
    assign w_unused_addr_lo = ^addr_lo;
    assign w_fault          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_size  <= SIZE_WORD;
            r_fault <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_size  <= w_op;
                        r_fault <= w_fault;
                        // Preloaded here so RD_WAIT lasts exactly MEM_LAT cycles
                        r_cnt   <= c_LAT_M1;
                        if (w_fault) begin
                            r_state <= ST_DONE;
                        end else if (w_op == SIZE_WORD) begin
                            r_state <= ST_WRITE;
                        end else begin
                            r_state <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_LD_MDR;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_LD_MDR: r_state <= ST_WRITE;
                ST_WRITE:  r_state <= ST_DONE;
                ST_DONE:   r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // Moore decode: strobes are one-hot by construction of the state encoding
    always_comb begin
        busy      = (r_state != ST_IDLE);
        done      = (r_state == ST_DONE);
        mem_rd    = (r_state == ST_RD_WAIT);
        mdr_load  = (r_state == ST_LD_MDR);
        mem_wr    = (r_state == ST_WRITE);
        size_ctrl = (r_state == ST_IDLE) ? SIZE_WORD : r_size;
`ifdef STORE_ALIGN_CHECK_EN
        misalign  = (r_state == ST_DONE) && r_fault;
`else
        misalign  = 1'b0;
`endif
    end

`ifndef STORE_ALIGN_CHECK_EN
    logic w_unused_fault;
    assign w_unused_fault = r_fault;
`endif

endmodule : store_size_sequencer
`default_nettype wire

// File: doc/store_size_sequencer.md
Name: store_size_sequencer

Overview:
- Multicycle control FSM that sequences sw/sh/sb stores through the memory, MDR and store-size merge datapath.
- Word stores write directly.
- Halfword and byte stores run read-modify-write:
  - read the target word into MDR;
  - drive the merge-mux select so it combines upper MDR bits with low bits of B;
  - write the merged word back.
- Sits beside the main control unit, which hands it one store at a time and stalls on busy.

Parameters:
- MEM_LAT, 1: cycles mem_rd is held before read data is valid at the MDR input. Legal range 1..15.
- CNT_W, 4: width of the internal latency counter. Must satisfy 2^CNT_W > MEM_LAT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  store request; sampled only in IDLE
- store_op  in  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as word)
- addr_lo  in  2  effective address bits [1:0]; used only by the optional feature
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- mem_rd  out  1  memory read enable
- mem_wr  out  1  memory write enable
- mdr_load  out  1  MDR write enable
- size_ctrl  out  2  merge-mux select: 01 half, 10 byte, 00 word/pass-B
- misalign  out  1  alignment fault pulse; tied 0 unless the optional feature is compiled in

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port named reset.
- Reset values: all outputs 0, state IDLE, counter 0.
- A reset asserted mid-operation aborts the store; no mem_wr is issued on the following cycle.
- States: IDLE, RD_WAIT, LD_MDR, WRITE, DONE.
- IDLE:
  - start=1 latches store_op (11 mapped to 00) and addr_lo.
  - Next state is WRITE for word, RD_WAIT for half or byte.
  - start=0 keeps the FSM in IDLE.
- RD_WAIT:
  - mem_rd=1 for exactly MEM_LAT cycles; the counter loads MEM_LAT-1 on entry and counts down.
  - Exits to LD_MDR when the counter reaches 0.
- LD_MDR: mdr_load=1 for one cycle, mem_rd=0; next state WRITE.
- WRITE: mem_wr=1 for one cycle; next state DONE.
- DONE: done=1 for one cycle; next state IDLE. A new start can be accepted in the cycle after DONE.
- size_ctrl:
  - Driven from the latched op in every non-IDLE state.
  - 00 in IDLE.
  - Stable through WRITE, so the merge output is valid while mem_wr is high.
- busy is 1 in every non-IDLE state.
- mem_rd, mem_wr and mdr_load are mutually exclusive in every cycle.
- Latency, with start accepted at cycle 0:
  - word: mem_wr at cycle 1, done at cycle 2;
  - half/byte: mem_rd at cycles 1..MEM_LAT, mdr_load at MEM_LAT+1, mem_wr at MEM_LAT+2, done at MEM_LAT+3.
- start asserted while busy is ignored; no queueing.
- store_op and addr_lo changes after acceptance have no effect.

Optional Feature:
- Macro: STORE_ALIGN_CHECK_EN.
- When defined:
  - In IDLE, an accepted start with a half op and addr_lo[0]=1, or a word op and addr_lo!=00, is a fault.
  - On a fault the FSM goes directly to DONE: no mem_rd, mem_wr or mdr_load is issued.
  - misalign=1 in the same cycle as done.
  - Byte stores never fault.
- When undefined: misalign is constant 0 and every store proceeds normally.

Decomposition:
- Package store_seq_pkg holds:
  - the state enum;
  - SIZE_WORD=2'b00, SIZE_HALF=2'b01, SIZE_BYTE=2'b10;
  - OP_RSVD=2'b11.
- Single module; the latency counter stays inline, since a sub-module adds nothing.

Test Plan:
All scenarios use MEM_LAT=2.
- Word store: start, op=00 at cycle 0 → mem_wr=1 at cycle 1, size_ctrl=00, done at cycle 2; mem_rd never asserts.
- Byte store: op=10 → mem_rd at cycles 1-2, mdr_load at cycle 3, mem_wr at cycle 4 with size_ctrl=10, done at cycle 5.
- Halfword store with start held high throughout → second store accepted only at cycle 6; mid-operation starts ignored and busy continuous.
- Reset asserted at cycle 3 of a halfword store → cycle 4: all outputs 0, state IDLE, no mem_wr.
- Reserved op=11 → behaves as a word store with size_ctrl=00.
- With STORE_ALIGN_CHECK_EN: half with addr_lo=01 → done and misalign at cycle 1, no memory strobes. Byte with addr_lo=11 → normal 5-cycle store, misalign=0.
